// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with an internal fixed-priority / round-robin
// arbiter feeding a single registered output stage with valid/ready.
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS-1);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_sel_reg;
  logic                out_valid_reg;
  logic [SEL_W-1:0]    ptr_reg;
  logic [SEL_W-1:0]    ptr_next;
  logic                load;
  logic                found;
  logic [SEL_W-1:0]    gidx;
  logic [SEL_W-1:0]    base;
  logic [SEL_W:0]      idx;
  logic [CHANNELS-1:0] grant;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;
  assign base = mode ? ptr_reg : '0;

  // Search starts at base and wraps; the first valid channel found wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    grant = '0;
    if (load && !rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = {1'b0, base} + (SEL_W+1)'(k);
        if (idx >= CH_COUNT) idx = idx - CH_COUNT;
        if (!found && in_valid[idx[SEL_W-1:0]]) begin
          found = 1'b1;
          gidx  = idx[SEL_W-1:0];
        end
      end
      if (found) grant[gidx] = 1'b1;
    end
  end

  assign ptr_next = (gidx == LAST_CH) ? '0 : gidx + 1'b1;
  assign in_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      out_valid_reg <= found;
      if (found) begin
        out_data_reg <= ch_data[gidx];
        out_sel_reg  <= gidx;
        if (mode) ptr_reg <= ptr_next;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: directed vector table, then random traffic
// checked against a cycle-level reference model of the arbiter rules.
module tb_mux_rr_stream;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [S-1:0]     out_sel;

  int vectors = 0;
  int miscompares = 0;

  mux_rr_stream #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic m, input logic [3:0] v,
                     input logic [31:0] d, input logic o, input logic [3:0] er,
                     input logic ev, input logic [7:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r; t.mode = m; t.vld = v; t.data = d; t.ordy = o;
    t.er = er; t.ev = ev; t.ed = ed; t.es = es;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [3:0] v,
                       input logic [31:0] d, input logic o);
    @(negedge clk);
    rst = r; mode = m; in_valid = v; in_data = d; out_ready = o;
    #1;
  endtask

  // Reference model state
  logic       m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_ptr;

  localparam logic [31:0] DA = 32'hA3A2A1A0;
  localparam logic [31:0] D0 = 32'h33221100;
  localparam logic [31:0] DB = 32'h335A1144;

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // reset with all inputs valid
    add(1, 0, 4'hF, DA, 1, 4'h0, 0, 8'h00, 0);
    add(1, 0, 4'hF, DA, 1, 4'h0, 0, 8'h00, 0);
    // round-robin: 0,1,2,3,0 with no bubbles
    add(0, 1, 4'hF, DA, 1, 4'h1, 1, 8'hA0, 0);
    add(0, 1, 4'hF, DA, 1, 4'h2, 1, 8'hA1, 1);
    add(0, 1, 4'hF, DA, 1, 4'h4, 1, 8'hA2, 2);
    add(0, 1, 4'hF, DA, 1, 4'h8, 1, 8'hA3, 3);
    add(0, 1, 4'hF, DA, 1, 4'h1, 1, 8'hA0, 0);
    // fixed priority: ch1 always wins over ch2/ch3
    add(0, 0, 4'hE, D0, 1, 4'h2, 1, 8'h11, 1);
    add(0, 0, 4'hE, D0, 1, 4'h2, 1, 8'h11, 1);
    add(0, 0, 4'hE, D0, 1, 4'h2, 1, 8'h11, 1);
    // backpressure holding 5A from ch2, then reload on the same edge
    add(0, 0, 4'h4, DB, 1, 4'h4, 1, 8'h5A, 2);
    add(0, 0, 4'hF, DB, 0, 4'h0, 1, 8'h5A, 2);
    add(0, 0, 4'hF, DB, 0, 4'h0, 1, 8'h5A, 2);
    add(0, 0, 4'hF, DB, 0, 4'h0, 1, 8'h5A, 2);
    add(0, 0, 4'hF, DB, 1, 4'h1, 1, 8'h44, 0);
    // no valid input: bubble, data/sel hold
    add(0, 0, 4'h0, DB, 1, 4'h0, 0, 8'h44, 0);
    add(0, 0, 4'h0, DB, 0, 4'h0, 0, 8'h44, 0);
    // pointer wrap and skip (ptr=1 -> ch2, ptr=3 -> ch0, ptr=1 -> ch2)
    add(0, 1, 4'h4, DB, 1, 4'h4, 1, 8'h5A, 2);
    add(0, 1, 4'h5, DB, 1, 4'h1, 1, 8'h44, 0);
    add(0, 1, 4'h5, DB, 1, 4'h4, 1, 8'h5A, 2);
    // mode change keeps ptr=3
    add(0, 0, 4'h5, DB, 1, 4'h1, 1, 8'h44, 0);
    add(0, 1, 4'h9, DB, 1, 4'h8, 1, 8'h33, 3);
    // reset mid-stream drops pending word and clears ptr
    add(0, 1, 4'h2, DB, 1, 4'h2, 1, 8'h11, 1);
    add(0, 1, 4'hF, DB, 0, 4'h0, 1, 8'h11, 1);
    add(1, 1, 4'hF, DB, 0, 4'h0, 0, 8'h00, 0);
    add(0, 1, 4'hF, DB, 0, 4'h1, 1, 8'h44, 0);
    // first grant after reset in fixed mode is ch0
    add(1, 0, 4'hF, DB, 1, 4'h0, 0, 8'h00, 0);
    add(0, 0, 4'hF, DB, 1, 4'h1, 1, 8'h44, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].vld, tbl[i].data, tbl[i].ordy);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(tbl[i].es));
      $display("vec %0d: rst=%0b mode=%0b vld=%b ordy=%0b -> rdy=%b ov=%0b od=%02h os=%0d",
               i, tbl[i].rst, tbl[i].mode, tbl[i].vld, tbl[i].ordy,
               in_ready, out_valid, out_data, out_sel);
    end

    // Random traffic against the reference model; first cycle is a reset.
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    for (int n = 0; n < 400; n++) begin
      logic        r, m, o;
      logic [3:0]  v;
      logic [31:0] d;
      logic        load;
      int          pick;
      logic [3:0]  exp_rdy;

      r = (n == 0) || ($urandom_range(99) < 3);
      m = 1'(($urandom_range(9) < 6) ? (n / 40) % 2 : $urandom_range(1));
      v = 4'($urandom);
      d = $urandom;
      o = ($urandom_range(99) < 70);
      drive(r, m, v, d, o);

      load = !m_valid || o;
      pick = -1;
      if (load && !r) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = ((m ? m_ptr : 0) + k) % N;
          if (pick < 0 && v[c]) pick = c;
        end
      end
      exp_rdy = (pick >= 0) ? 4'(1 << pick) : 4'h0;
      chk($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(exp_rdy));

      if (r) begin
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (load) begin
        m_valid = (pick >= 0);
        if (pick >= 0) begin
          m_data = d[pick*W +: W];
          m_sel  = pick;
          if (m) m_ptr = (pick + 1) % N;
        end
      end

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(m_valid));
      chk($sformatf("rnd%0d out_data", n), 32'(out_data), 32'(m_data));
      chk($sformatf("rnd%0d out_sel", n), 32'(out_sel), 32'(m_sel));
      $display("rnd %0d: rst=%0b mode=%0b vld=%b ordy=%0b -> rdy=%b ov=%0b od=%02h os=%0d",
               n, r, m, v, o, in_ready, out_valid, out_data, out_sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel, W-bit stream multiplexer with per-channel valid/ready handshakes and one registered output stage.
- Next-generation replacement for the plain combinational 4:1 byte select. The select is generated internally by an arbiter instead of being driven by an external select bus.
- Sits between several producer blocks (ALU results, register-file reads, I/O) and one shared consumer. Fixed-priority or round-robin arbitration is chosen at run time.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, width of the channel index; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  bit i high: channel i presents a word.
- in_ready  output  CHANNELS  bit i high: channel i's word is accepted this cycle (combinational).
- mode  input  1  0 = fixed priority, channel 0 highest; 1 = round-robin.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_sel  output  SEL_W  index of the channel that supplied out_data (registered).

Behaviour:
- Reset:
  - Sampled on a clk edge with rst=1.
  - Drives out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - Overrides any transfer in the same cycle.
  - A word held in the output register when rst is asserted is discarded.
  - While rst=1, in_ready=0.
- Load enable: load = !out_valid || out_ready. The output register can take a new word when it is empty or being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - Computed only when load=1 and rst=0; otherwise grant=0.
  - mode=0: lowest-index channel with in_valid=1.
  - mode=1: first channel with in_valid=1 searching ptr, ptr+1, ... wrapping modulo CHANNELS.
  - No valid input: grant=0.
- in_ready = grant. At most one bit of in_ready is high in any cycle.
- Transfer at clk edge when grant has bit g set:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - If mode=1: ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - If mode=0: ptr holds.
- No grant and load=1: out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid held stable and in_ready=0. No word is lost or duplicated.
- Latency and throughput:
  - Latency is 1 cycle, from the input handshake to out_valid.
  - Sustained throughput is 1 word per cycle when out_ready is held high.
- Simultaneous drain and fill (out_valid=1, out_ready=1, some in_valid): the new word is loaded in the same edge with no bubble.
- mode change: takes effect at the next grant evaluation. ptr is not reset by the change.
- Producer rule: in_data[i] must stay stable while in_valid[i]=1 and in_ready[i]=0. The block does not check this rule.
- Out-of-range ptr values cannot occur.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. After rst falls, first grant is ch0 in both modes.
- Fixed priority: mode=0, in_valid=4'b1110, data ch1..3 = 8'h11, 8'h22, 8'h33, out_ready=1 held, valids held -> out_sel=1 with out_data=8'h11 every cycle; ch2 and ch3 are never granted.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, data ch0..3 = 8'hA0..8'hA3, out_ready=1 -> out_sel sequence 0,1,2,3,0,... on consecutive cycles, one word per cycle, no bubbles.
- Backpressure: out_ready=0 for 3 cycles after a word 8'h5A from ch2 -> out_data=8'h5A, out_sel=2, out_valid=1 stable, in_ready=0 all cycles. When out_ready rises, the next word loads on the same edge.
- Pointer wrap and skip: mode=1, ptr=3, in_valid=4'b0101 -> ch0 granted and ptr=1; next grant ch2 and ptr=3.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0 and ptr=0; the pending word is dropped.
